stack: RTL and testbench



---
 rtl/stack.sv | 136 +++++++++++++
 tb/tb_stack.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack.sv
// ---------------------------------------------------------------------------
// stack : LIFO operand store for the RPN calculator ALU.
//
// Push and pop requests are edge-detected strobes: a strobe held high for
// several cycles performs exactly one operation. The top entry is exposed
// combinationally on POP_DAT/POP_STB with zero latency after the update edge.
// A simultaneous push and pop replaces the top entry in place.
//
// Optional feature macro: STACK_ERR_EN
//   defined   -> ERR port present; sticky overflow/underflow flag.
//   undefined -> no ERR port; overflow/underflow silently ignored.
// ---------------------------------------------------------------------------
module stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PUSH_STB,
   input  logic [WIDTH-1:0] PUSH_DAT,
   output logic             PUSH_ACK,
   output logic             POP_STB,
   output logic [WIDTH-1:0] POP_DAT,
   input  logic             POP_ACK
`ifdef STACK_ERR_EN
   ,
   output logic             ERR
`endif
);

   // Index width addresses the storage; count needs one extra bit so that
   // "full" (count == DEPTH) is representable without wrapping.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_prev_push;
   logic             r_prev_pop;
   logic             r_push_ack;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic             w_push_req;
   logic             w_pop_req;
   logic             w_empty;
   logic             w_full;
   logic             w_replace;
   logic             w_do_push;
   logic             w_do_pop;
   logic             w_wr_en;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_wr_idx;

   // Rising edge of each strobe against its registered previous level.
   assign w_push_req = PUSH_STB & ~r_prev_push;
   assign w_pop_req  = POP_ACK  & ~r_prev_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // Push and pop together on a non-empty stack overwrite the top in place,
   // which also works when full. On an empty stack the pair degrades to a
   // plain push, which is covered by w_do_push below.
   assign w_replace = w_push_req & w_pop_req & ~w_empty;
   assign w_do_push = w_push_req & ~w_replace & ~w_full;
   assign w_do_pop  = w_pop_req  & ~w_push_req & ~w_empty;

   // When full the low AW bits of the count are zero, so subtracting one
   // wraps to DEPTH-1, which is exactly the top index.
   assign w_top_idx = r_count[AW-1:0] - AW'(1);
   assign w_wr_idx  = w_replace ? w_top_idx : r_count[AW-1:0];

   // A reset edge discards any request arriving in the same cycle.
   assign w_wr_en = ~RST & (w_replace | w_do_push);

   // Control state: count, strobe history and the acknowledge pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count     <= '0;
         r_prev_push <= 1'b0;
         r_prev_pop  <= 1'b0;
         r_push_ack  <= 1'b0;
      end else begin
         r_prev_push <= PUSH_STB;
         r_prev_pop  <= POP_ACK;
         r_push_ack  <= w_replace | w_do_push;
         if (w_do_push) begin
            r_count <= r_count + CW'(1);
         end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Storage write port; contents are intentionally not cleared by reset.
   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= PUSH_DAT;
      end
   end

`ifdef STACK_ERR_EN
   logic r_err;
   logic w_err_event;

   // A lone push on a full stack or a lone pop on an empty one is an error;
   // a replace never is.
   assign w_err_event = (w_push_req & ~w_pop_req  & w_full) |
                        (w_pop_req  & ~w_push_req & w_empty);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_err <= 1'b0;
      end else if (w_err_event) begin
         r_err <= 1'b1;
      end
   end

   assign ERR = r_err;
`endif

   // ------------------------------------------------------------------
   // Outputs: top of stack is combinational from the registers.
   // ------------------------------------------------------------------
   assign PUSH_ACK = r_push_ack;
   assign POP_STB  = ~w_empty;
   assign POP_DAT  = w_empty ? '0 : r_mem[w_top_idx];

endmodule

// File: tb/tb_stack.sv
// ---------------------------------------------------------------------------
// tb_stack : self-checking bench for the LIFO stack.
// A queue-based reference model tracks the expected stack contents, ack
// pulse and error flag; directed scenarios and a randomized run compare the
// DUT outputs against it one time unit after each rising clock edge.
// ERR is only compared when STACK_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             CLK = 1'b0;
   logic             RST;
   logic             PUSH_STB;
   logic [WIDTH-1:0] PUSH_DAT;
   logic             PUSH_ACK;
   logic             POP_STB;
   logic [WIDTH-1:0] POP_DAT;
   logic             POP_ACK;
`ifdef STACK_ERR_EN
   logic             ERR;
`endif

   stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PUSH_STB (PUSH_STB),
      .PUSH_DAT (PUSH_DAT),
      .PUSH_ACK (PUSH_ACK),
      .POP_STB  (POP_STB),
      .POP_DAT  (POP_DAT),
      .POP_ACK  (POP_ACK)
`ifdef STACK_ERR_EN
      ,
      .ERR      (ERR)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the stack as a queue whose back is the top.
   logic [WIDTH-1:0] m_q [$];
   bit               m_prev_push;
   bit               m_prev_pop;
   bit               m_ack;
   bit               m_err;

   function automatic logic [WIDTH-1:0] exp_top();
      if (m_q.size() == 0) return '0;
      return m_q[m_q.size()-1];
   endfunction

   // Advance one clock edge, apply the rules to the model, settle.
   task automatic tick();
      bit pr;
      bit po;
      @(posedge CLK);
      if (RST) begin
         m_q.delete();
         m_prev_push = 0;
         m_prev_pop  = 0;
         m_ack       = 0;
         m_err       = 0;
      end else begin
         pr = PUSH_STB && !m_prev_push;
         po = POP_ACK  && !m_prev_pop;
         m_ack = 0;
         if (pr && po) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = PUSH_DAT;
            else                m_q.push_back(PUSH_DAT);
            m_ack = 1;
         end else if (pr) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(PUSH_DAT);
               m_ack = 1;
            end else begin
               m_err = 1;
            end
         end else if (po) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else                m_err = 1;
         end
         m_prev_push = PUSH_STB;
         m_prev_pop  = POP_ACK;
      end
      #1;
   endtask

   task automatic do_reset();
      RST = 1; PUSH_STB = 0; POP_ACK = 0;
      tick();
      RST = 0;
      tick();
   endtask

   task automatic push_pulse(input logic [WIDTH-1:0] d);
      PUSH_DAT = d; PUSH_STB = 1;
      tick();
      PUSH_STB = 0;
      tick();
   endtask

   task automatic pop_pulse();
      POP_ACK = 1;
      tick();
      POP_ACK = 0;
      tick();
   endtask

   task automatic test_reset();
      RST = 1; PUSH_STB = 0; POP_ACK = 0; PUSH_DAT = '0;
      tick(); tick();
      RST = 0;
      tick(); tick();
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL reset_pop_stb: got %0b want 0", POP_STB); end
      n_tests++;
      if (POP_DAT !== 8'h00) begin n_fail++; $display("FAIL reset_pop_dat: got %0h want 0", POP_DAT); end
      n_tests++;
      if (PUSH_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_push_ack: got %0b want 0", PUSH_ACK); end
`ifdef STACK_ERR_EN
      n_tests++;
      if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", ERR); end
`endif
   endtask

   task automatic test_push_pop();
      int acks = 0;
      do_reset();
      PUSH_DAT = 8'h33; PUSH_STB = 1;
      repeat (3) begin
         tick();
         if (PUSH_ACK === 1'b1) acks++;
      end
      PUSH_STB = 0;
      tick();
      if (PUSH_ACK === 1'b1) acks++;
      n_tests++;
      if (acks != 1) begin n_fail++; $display("FAIL held_push_acks: got %0d want 1", acks); end
      PUSH_DAT = 8'h35; PUSH_STB = 1;
      tick();
      n_tests++;
      if (PUSH_ACK !== 1'b1) begin n_fail++; $display("FAIL push2_ack: got %0b want 1", PUSH_ACK); end
      PUSH_STB = 0;
      tick();
      n_tests++;
      if (PUSH_ACK !== 1'b0) begin n_fail++; $display("FAIL push2_ack_drop: got %0b want 0", PUSH_ACK); end
      n_tests++;
      if (POP_DAT !== 8'h35) begin n_fail++; $display("FAIL push2_top: got %0h want 35", POP_DAT); end
      // Hold POP_ACK two cycles: only one pop may happen.
      POP_ACK = 1;
      tick(); tick();
      n_tests++;
      if (POP_DAT !== 8'h33) begin n_fail++; $display("FAIL pop1_top: got %0h want 33", POP_DAT); end
      n_tests++;
      if (POP_STB !== 1'b1) begin n_fail++; $display("FAIL pop1_stb: got %0b want 1", POP_STB); end
      POP_ACK = 0;
      tick();
      pop_pulse();
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL pop2_stb: got %0b want 0", POP_STB); end
      n_tests++;
      if (POP_DAT !== 8'h00) begin n_fail++; $display("FAIL pop2_dat: got %0h want 0", POP_DAT); end
   endtask

   task automatic test_replace();
      do_reset();
      push_pulse(8'h32);
      push_pulse(8'h34);
      PUSH_DAT = 8'h36; PUSH_STB = 1; POP_ACK = 1;
      tick();
      n_tests++;
      if (PUSH_ACK !== 1'b1) begin n_fail++; $display("FAIL replace_ack: got %0b want 1", PUSH_ACK); end
      n_tests++;
      if (POP_DAT !== 8'h36) begin n_fail++; $display("FAIL replace_top: got %0h want 36", POP_DAT); end
      PUSH_STB = 0; POP_ACK = 0;
      tick();
      pop_pulse();
      n_tests++;
      if (POP_DAT !== 8'h32) begin n_fail++; $display("FAIL replace_below: got %0h want 32", POP_DAT); end
      pop_pulse();
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL replace_depth: got %0b want 0", POP_STB); end
      // Replace on empty acts as a plain push.
      PUSH_DAT = 8'h5A; PUSH_STB = 1; POP_ACK = 1;
      tick();
      n_tests++;
      if (POP_DAT !== 8'h5A || PUSH_ACK !== 1'b1) begin
         n_fail++; $display("FAIL replace_empty: got dat %0h ack %0b want 5a 1", POP_DAT, PUSH_ACK);
      end
      PUSH_STB = 0; POP_ACK = 0;
      tick();
   endtask

   task automatic test_overflow();
      int acks = 0;
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         PUSH_DAT = 8'(i); PUSH_STB = 1;
         tick();
         if (PUSH_ACK === 1'b1) acks++;
         PUSH_STB = 0;
         tick();
      end
      n_tests++;
      if (acks != 16) begin n_fail++; $display("FAIL overflow_acks: got %0d want 16", acks); end
      n_tests++;
      if (POP_DAT !== 8'h10) begin n_fail++; $display("FAIL overflow_top: got %0h want 10", POP_DAT); end
`ifdef STACK_ERR_EN
      n_tests++;
      if (ERR !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %0b want 1", ERR); end
`endif
      // Replace while full.
      PUSH_DAT = 8'h77; PUSH_STB = 1; POP_ACK = 1;
      tick();
      n_tests++;
      if (PUSH_ACK !== 1'b1 || POP_DAT !== 8'h77) begin
         n_fail++; $display("FAIL full_replace: got ack %0b dat %0h want 1 77", PUSH_ACK, POP_DAT);
      end
      PUSH_STB = 0; POP_ACK = 0;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         pop_pulse();
         n_tests++;
         if (POP_DAT !== exp_top()) begin
            n_fail++; $display("FAIL drain_%0d: got %0h want %0h", i, POP_DAT, exp_top());
         end
      end
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0b want 0", POP_STB); end
   endtask

   task automatic test_underflow();
      do_reset();
      POP_ACK = 1;
      tick();
      n_tests++;
      if (POP_STB !== 1'b0 || POP_DAT !== 8'h00) begin
         n_fail++; $display("FAIL underflow_state: got stb %0b dat %0h want 0 0", POP_STB, POP_DAT);
      end
`ifdef STACK_ERR_EN
      n_tests++;
      if (ERR !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %0b want 1", ERR); end
`endif
      POP_ACK = 0;
      tick();
      push_pulse(8'h41);
      pop_pulse();
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL underflow_nowrap: got %0b want 0", POP_STB); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push_pulse(8'h31);
      n_tests++;
      if (POP_DAT !== 8'h31) begin n_fail++; $display("FAIL mid_first: got %0h want 31", POP_DAT); end
      PUSH_DAT = 8'h39; PUSH_STB = 1; RST = 1;
      tick();
      n_tests++;
      if (POP_STB !== 1'b0 || PUSH_ACK !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got stb %0b ack %0b want 0 0", POP_STB, PUSH_ACK);
      end
      RST = 0;
      tick();
      n_tests++;
      if (POP_DAT !== 8'h39 || PUSH_ACK !== 1'b1) begin
         n_fail++; $display("FAIL mid_post_push: got dat %0h ack %0b want 39 1", POP_DAT, PUSH_ACK);
      end
      tick();
      n_tests++;
      if (PUSH_ACK !== 1'b0) begin n_fail++; $display("FAIL mid_once: got %0b want 0", PUSH_ACK); end
      PUSH_STB = 0;
      tick();
      pop_pulse();
      n_tests++;
      if (POP_STB !== 1'b0) begin n_fail++; $display("FAIL mid_single: got %0b want 0", POP_STB); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         PUSH_STB = ($urandom_range(0, 99) < 60);
         POP_ACK  = ($urandom_range(0, 99) < 40);
         PUSH_DAT = 8'($urandom);
         RST      = ($urandom_range(0, 199) == 0);
         tick();
         n_tests++;
         if (POP_STB !== (m_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_stb@%0d: got %0b want %0b", c, POP_STB, m_q.size() != 0);
         end
         n_tests++;
         if (POP_DAT !== exp_top()) begin
            n_fail++; $display("FAIL rand_dat@%0d: got %0h want %0h", c, POP_DAT, exp_top());
         end
         n_tests++;
         if (PUSH_ACK !== m_ack) begin
            n_fail++; $display("FAIL rand_ack@%0d: got %0b want %0b", c, PUSH_ACK, m_ack);
         end
`ifdef STACK_ERR_EN
         n_tests++;
         if (ERR !== m_err) begin
            n_fail++; $display("FAIL rand_err@%0d: got %0b want %0b", c, ERR, m_err);
         end
`endif
      end
      RST = 0; PUSH_STB = 0; POP_ACK = 0;
      tick();
   endtask

   initial begin
      RST = 1; PUSH_STB = 0; POP_ACK = 0; PUSH_DAT = '0;
      test_reset();
      test_push_pop();
      test_replace();
      test_overflow();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
